data_mem_responder: RTL and testbench

- Responder end of the core's data-memory load/store path.
- Replaces the zero-latency array with a handshaked, multi-cycle RAM slave.
- Accepts one request at a time from the load/store initiator, performs funct3-sized byte/half/word accesses with lane steering and sign extension, and returns a registered response after a configurable wait-state count.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_lane_align.sv | 52 +++++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared funct3 encodings, responder state and widths
package data_mem_responder_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// rtl/data_mem_responder_lane_align.sv - byte-lane steering for stores and load extension
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] rep_word;
    logic [31:0] shifted;

    always_comb begin
        be_o     = 4'b0000;
        rep_word = wdata_i;
        case (funct3_i)
            F3_B: begin
                be_o     = 4'b0001 << offset_i;
                rep_word = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o     = offset_i[1] ? 4'b1100 : 4'b0011;
                rep_word = {2{wdata_i[15:0]}};
            end
            F3_W:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            wr_word_o[8*b +: 8] = be_o[b] ? rep_word[8*b +: 8] : old_word_i[8*b +: 8];
        end
    end

    // Offset is already forced to the access's natural alignment upstream.
    assign shifted = rd_word_i >> {offset_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data_o = {24'h0, shifted[7:0]};
            F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data_o = {16'h0, shifted[15:0]};
            F3_W:    ld_data_o = rd_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked multi-cycle data RAM slave; MISALIGN_ERR_EN faults misaligned accesses
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    rsp_state_e            state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [2:0]            f3_q;
    logic [31:0]           wdata_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic [31:0] mem_q [DEPTH];

    logic              direct_acc;
    logic              acc_wr;
    logic [31:0]       acc_addr;
    logic [2:0]        acc_f3;
    logic [31:0]       acc_wdata;
    logic              do_access;
    logic              f3_bad;
    logic              oor;
    logic              misalign;
    logic              is_half;
    logic              is_word;
    logic              acc_err;
    logic [1:0]        acc_off;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic [3:0]        be;
    logic [31:0]       wr_word;
    logic [31:0]       ld_data;
    logic [31:0]       rdata_d;
    logic              mem_we;

    // With zero wait states the access uses the live request on the accept edge.
    assign direct_acc = (WAIT_CYCLES == 0) && (state_q == IDLE);
    assign acc_wr     = direct_acc ? req_write  : wr_q;
    assign acc_addr   = direct_acc ? req_addr   : addr_q;
    assign acc_f3     = direct_acc ? req_funct3 : f3_q;
    assign acc_wdata  = direct_acc ? req_wdata  : wdata_q;

    assign do_access = (direct_acc && req_valid) || (state_q == WAIT && cnt_q == '0);

    assign f3_bad  = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111) ||
                     (acc_wr && (acc_f3 == F3_BU || acc_f3 == F3_HU));
    assign oor     = |acc_addr[31:ADDR_W+2];
    assign is_half = (acc_f3 == F3_H) || (acc_f3 == F3_HU);
    assign is_word = (acc_f3 == F3_W);

`ifdef MISALIGN_ERR_EN
    assign misalign = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
    assign acc_off  = acc_addr[1:0];
`else
    assign misalign = 1'b0;
    assign acc_off  = is_word ? 2'b00 : (is_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif

    assign acc_err  = f3_bad || oor || misalign;
    assign idx      = acc_addr[ADDR_W+1:2];
    assign old_word = mem_q[idx];
    assign mem_we   = do_access && acc_wr && !acc_err;
    assign rdata_d  = (acc_err || acc_wr) ? 32'h0 : ld_data;

    mem_lane_align u_align (
        .funct3_i   (acc_f3),
        .offset_i   (acc_off),
        .wdata_i    (acc_wdata),
        .old_word_i (old_word),
        .rd_word_i  (old_word),
        .be_o       (be),
        .wr_word_o  (wr_word),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            f3_q        <= 3'b000;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        f3_q        <= req_funct3;
                        wdata_q     <= req_wdata;
                        cnt_q       <= WAIT_CNT_W'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_d;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder (WAIT_CYCLES=1 and 3 instances)
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid3 = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        rsp_ready3 = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int lat);
        int n;
        req_write = w; req_addr = a; req_funct3 = f3; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid=%b required 1", a, rsp_valid);
        end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic issue3(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        req_write = w; req_addr = a; req_funct3 = f3; req_wdata = d; req_valid3 = 1'b1;
        n = 0;
        while (!req_ready3 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        n = 0;
        while (!rsp_valid3 && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (rsp_valid3 !== 1'b1) begin
            errors++;
            $display("FAIL rsp3_timeout addr=%h: rsp_valid=%b required 1", a, rsp_valid3);
        end
        rd = rsp_rdata3; er = rsp_err3;
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, F3_W, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
        checks++;
        if ({er, rd} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL sw_rsp: err=%b rdata=%h required 0 00000000", er, rd);
        end
        issue(1'b0, 32'h10, F3_W, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_10: err=%b rdata=%h required 0 deadbeef", er, rd);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h20, F3_W, 32'h0, rd, er, lat);
        issue(1'b1, 32'h23, F3_B, 32'hFFFFFF80, rd, er, lat);
        issue(1'b0, 32'h23, F3_B, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_23: got %h required ffffff80", rd); end
        issue(1'b0, 32'h23, F3_BU, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_23: got %h required 00000080", rd); end
        issue(1'b1, 32'h20, F3_H, 32'hABCD8001, rd, er, lat);
        issue(1'b0, 32'h20, F3_W, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h80008001) begin errors++; $display("FAIL lw_20: got %h required 80008001", rd); end
        issue(1'b0, 32'h22, F3_H, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL lh_22: got %h required ffff8000", rd); end
        issue(1'b0, 32'h22, F3_HU, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00008000) begin errors++; $display("FAIL lhu_22: got %h required 00008000", rd); end
    endtask

    task automatic test_backpressure();
        int n;
        req_write = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h20;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL bp_hold c%0d: valid=%b ready=%b rdata=%h required 1 0 deadbeef",
                         c, rsp_valid, req_ready, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_second_accept: ready=%b required 0", req_ready);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h80008001}) begin
            errors++; $display("FAIL bp_second_rsp: valid=%b rdata=%h required 1 80008001", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        issue(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL bad_f3: err=%b rdata=%h required 1 00000000", er, rd);
        end
        issue(1'b1, 32'h0, F3_W, 32'h11223344, rd, er, lat);
        issue(1'b1, 32'h1000, F3_W, 32'hFFFFFFFF, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL oor_sw: err=%b required 1", er); end
        issue(1'b1, 32'h0, F3_BU, 32'h000000AA, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL store_bu: err=%b required 1", er); end
        issue(1'b0, 32'h0, F3_W, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h11223344}) begin
            errors++; $display("FAIL lw_0_intact: err=%b rdata=%h required 0 11223344", er, rd);
        end
        issue(1'b0, 32'h22, F3_W, 32'h0, rd, er, lat);
        checks++;
`ifdef MISALIGN_ERR_EN
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL lw_misalign: err=%b rdata=%h required 1 00000000", er, rd);
        end
`else
        if ({er, rd} !== {1'b0, 32'h80008001}) begin
            errors++; $display("FAIL lw_misalign: err=%b rdata=%h required 0 80008001", er, rd);
        end
`endif
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er;
        logic seen;
        issue3(1'b1, 32'h30, F3_W, 32'hCAFEF00D, rd, er);
        req_write = 1'b1; req_addr = 32'h30; req_funct3 = F3_W; req_wdata = 32'h12345678;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_rsp: saw rsp_valid=%b required 0", seen); end
        issue3(1'b0, 32'h30, F3_W, 32'h0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL midop_lw_30: err=%b rdata=%h required 0 cafef00d", er, rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_backpressure();
        test_errors();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
